cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
//  Memory-side responder for the pipelined CPU's instruction-fetch and data ports.
//  Word-addressed unified array with two ports:
//  - fixed-latency pipelined instruction port;
//  - valid/ready data port whose latency is set by a parameter, so stall logic can be exercised.
//  A loader port preloads programs. The block sits beside the CPU in the top-level testbench/SoC.
// PARAMETERS
//  ADDR_W    10  word-address bits; DEPTH = 2**ADDR_W words of 32 bits
//  DATA_LAT  2   data-port latency in cycles from acceptance to response; legal range 1..15
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   asynchronous, active-high reset
//  i_req     in   1   instruction fetch request, may be high every cycle
//  i_addr    in   32  fetch byte address
//  i_valid   out  1   fetch response valid
//  i_data    out  32  fetched word
//  i_err     out  1   fetch address misaligned (i_addr[1:0]!=0)
//  d_req     in   1   data request valid
//  d_we      in   1   1=store, 0=load
//  d_addr    in   32  data byte address
//  d_wdata   in   32  store data
//  d_ready   out  1   responder can accept a request this cycle
//  d_rvalid  out  1   data response valid, one-cycle pulse
//  d_rdata   out  32  load data; store echoes the write data
//  d_err     out  1   data address misaligned, qualified by d_rvalid
//  ld_we     in   1   loader write enable
//  ld_addr   in   ADDR_W  loader word address
//  ld_data   in   32  loader write data
// BEHAVIOUR
//  Addressing
//  - Word index = addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH.
//  - Array contents are unaffected by rst.
//  Reset values
//  - i_valid=0, i_data=0, i_err=0, d_rvalid=0, d_rdata=0, d_err=0.
//  - Data FSM is IDLE, so d_ready=1.
//  Instruction port
//  - Latency 1, fully pipelined.
//  - i_req in cycle N gives i_valid=1 in cycle N+1, with i_data = word at i_addr.
//  - i_req=0 gives i_valid=0 next cycle; i_data holds its last value.
//  - Misaligned: i_err=1, i_data=0.
//  Data FSM states: IDLE, WAIT, RESP
//  - d_ready = (state==IDLE || state==RESP). Accept when d_req && d_ready.
//  - On accept, capture we/addr/wdata. Go to RESP if DATA_LAT==1, else WAIT with cnt=DATA_LAT-2.
//  - WAIT: if cnt==0, go to RESP; else cnt decrements.
//  - RESP: d_rvalid=1 for exactly this cycle.
//  - RESP exit: back-to-back accept goes to WAIT/RESP as from IDLE; otherwise go to IDLE.
//  - Response is DATA_LAT cycles after the acceptance cycle. Throughput is one request per DATA_LAT cycles.
//  - Store commits to the array at the edge ending its RESP cycle. d_rdata=wdata.
//  - Load: d_rdata = array word including any write committed at or before the edge entering RESP (write-first).
//  - Misaligned load/store: full latency, d_err=1, d_rdata=0, no array write.
//  - d_req while d_ready=0 is ignored; no queueing. The requester must hold or retry.
//  - d_rdata/d_err hold their values after RESP until the next response.
//  Collisions
//  - A store committing at the same edge the instruction port samples the same word: i_data returns the new value.
//  - Loader write and data store to the same word at the same edge: the store wins.
//  - The loader writes at any posedge, including while rst=1.
//  Reset mid-operation
//  - Any in-flight data request is discarded: no write, no d_rvalid.
//  - FSM returns to IDLE; the instruction pipeline is cleared (i_valid=0).
// TESTING
//  1. Load word 5 = 0xDEADBEEF via loader; i_req, i_addr=0x14 -> next cycle i_valid=1, i_data=0xDEADBEEF, i_err=0.
//  2. DATA_LAT=3: store 0x12345678 to 0x40 at cycle 0 -> d_ready=0 in cycles 1-2, d_rvalid in cycle 3 only.
//     Then load 0x40 -> d_rdata=0x12345678.
//  3. Back-to-back: store 0xA to 0x8, then a load of 0x8 accepted in the store's RESP cycle.
//     -> The load returns 0xA (write-first), DATA_LAT cycles later.
//  4. d_addr=0x41 load -> d_rvalid with d_err=1, d_rdata=0.
//     i_addr=0x2 -> i_err=1. A misaligned store leaves the array unchanged.
//  5. Wrap: ADDR_W=10, store 0x55 to 0x1000 -> a load from 0x0 returns 0x55.
//  6. Assert rst one cycle before RESP of a store to 0x20 -> no d_rvalid.
//     Word 0x20 keeps its old value; d_ready=1 after reset.

Source files
------------

// File: rtl/cpu_mem_responder_if.sv
// Bus bundle between the CPU (master) and the memory responder (slave):
// pipelined fetch port, valid/ready data port and program loader port.
interface cpu_mem_responder_if #(
  parameter int ADDR_W = 10
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_valid;
  logic [31:0]       i_data;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ld_we, ld_addr, ld_data,
    input  i_valid, i_data, i_err, d_ready, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ld_we, ld_addr, ld_data,
    output i_valid, i_data, i_err, d_ready, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Unified word-addressed memory serving a 1-cycle pipelined fetch port and a
// fixed-latency valid/ready data port; contents survive reset.
module cpu_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int DATA_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  cpu_mem_responder_if.slave bus
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(DATA_LAT > 1 ? DATA_LAT - 2 : 0);

  typedef struct packed {
    logic              we;
    logic              err;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       wdata;
  } dreq_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  dreq_t             cur, in_req, src;
  logic              accept, enter_resp, st_commit;
  logic [31:0]       d_word, i_word;
  logic [ADDR_W-1:0] i_idx;
  logic              i_mis;
  logic              unused_bits;

  assign unused_bits = ^{bus.i_addr[31:ADDR_W+2], bus.d_addr[31:ADDR_W+2]};

  always_comb begin
    in_req       = '0;
    in_req.we    = bus.d_we;
    in_req.err   = (bus.d_addr[1:0] != 2'b00);
    in_req.idx   = bus.d_addr[ADDR_W+1:2];
    in_req.wdata = bus.d_wdata;
  end

  assign bus.d_ready  = (state == IDLE) || (state == RESP);
  assign bus.d_rvalid = (state == RESP);
  assign accept       = bus.d_req && bus.d_ready;
  assign st_commit    = (state == RESP) && cur.we && !cur.err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          cnt_nxt = CNT_INIT;
          if (DATA_LAT == 1) state_nxt = RESP;
          else               state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cur <= '0;
    else if (accept) cur <= in_req;
  end

  // Loader and store share the array; the store is written last so it wins.
  always_ff @(posedge clk) begin
    if (bus.ld_we) mem[bus.ld_addr] <= bus.ld_data;
    if (st_commit) mem[cur.idx]     <= cur.wdata;
  end

  // RESP is entered either from WAIT (captured request) or straight from accept.
  assign src        = (state == WAIT) ? cur : in_req;
  assign enter_resp = (state_nxt == RESP);

  always_comb begin
    d_word = mem[src.idx];
    if (st_commit && cur.idx == src.idx)          d_word = cur.wdata;
    else if (bus.ld_we && bus.ld_addr == src.idx) d_word = bus.ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.d_rdata <= '0;
      bus.d_err   <= 1'b0;
    end else if (enter_resp) begin
      bus.d_err <= src.err;
      if (src.err)     bus.d_rdata <= '0;
      else if (src.we) bus.d_rdata <= src.wdata;
      else             bus.d_rdata <= d_word;
    end
  end

  assign i_idx = bus.i_addr[ADDR_W+1:2];
  assign i_mis = (bus.i_addr[1:0] != 2'b00);

  always_comb begin
    i_word = mem[i_idx];
    if (st_commit && cur.idx == i_idx)          i_word = cur.wdata;
    else if (bus.ld_we && bus.ld_addr == i_idx) i_word = bus.ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.i_valid <= 1'b0;
      bus.i_data  <= '0;
      bus.i_err   <= 1'b0;
    end else begin
      bus.i_valid <= bus.i_req;
      if (bus.i_req) begin
        bus.i_err  <= i_mis;
        bus.i_data <= i_mis ? 32'h0 : i_word;
      end
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder with DATA_LAT=3, ADDR_W=10.
module tb_cpu_mem_responder;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cpu_mem_responder_if #(.ADDR_W(10)) bus();

  cpu_mem_responder #(.ADDR_W(10), .DATA_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic [9:0] a, input logic [31:0] v);
    bus.ld_we = 1'b1; bus.ld_addr = a; bus.ld_data = v;
    tick;
    bus.ld_we = 1'b0;
  endtask

  // One data transaction from IDLE; lat=0 means no response appeared.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    while (!bus.d_ready && n < 20) begin tick; n++; end
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    tick;
    bus.d_req = 1'b0;
    lat = 1;
    while (!bus.d_rvalid && lat < 20) begin tick; lat++; end
    if (!bus.d_rvalid) lat = 0;
    rdata = bus.d_rdata;
    err   = bus.d_err;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.ld_we = 0; bus.ld_addr = 0; bus.ld_data = 0;
    ld_write(10'd5, 32'hDEADBEEF);
    tick;
    checks++; if (bus.i_valid !== 1'b0) begin errors++; $display("FAIL rst_i_valid: got %b want 0", bus.i_valid); end
    checks++; if (bus.i_data !== 32'h0) begin errors++; $display("FAIL rst_i_data: got %h want 0", bus.i_data); end
    checks++; if (bus.i_err !== 1'b0) begin errors++; $display("FAIL rst_i_err: got %b want 0", bus.i_err); end
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_d_rvalid: got %b want 0", bus.d_rvalid); end
    checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL rst_d_rdata: got %h want 0", bus.d_rdata); end
    checks++; if (bus.d_err !== 1'b0) begin errors++; $display("FAIL rst_d_err: got %b want 0", bus.d_err); end
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL rst_d_ready: got %b want 1", bus.d_ready); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_ifetch;
    logic [31:0] addrs [4];
    logic [31:0] exp_d [4];
    logic        exp_e [4];
    addrs = '{32'h14, 32'h18, 32'h1C, 32'h2};
    exp_d = '{32'hDEADBEEF, 32'h66666666, 32'h77777777, 32'h0};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b1};
    ld_write(10'd6, 32'h66666666);
    ld_write(10'd7, 32'h77777777);
    bus.i_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_addr = addrs[i];
      tick;
      checks++; if (bus.i_valid !== 1'b1) begin errors++; $display("FAIL fetch%0d_valid: got %b want 1", i, bus.i_valid); end
      checks++; if (bus.i_data !== exp_d[i]) begin errors++; $display("FAIL fetch%0d_data: got %h want %h", i, bus.i_data, exp_d[i]); end
      checks++; if (bus.i_err !== exp_e[i]) begin errors++; $display("FAIL fetch%0d_err: got %b want %b", i, bus.i_err, exp_e[i]); end
    end
    bus.i_req = 1'b0;
    tick;
    checks++; if (bus.i_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle_valid: got %b want 0", bus.i_valid); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678;
    tick;
    bus.d_req = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (bus.d_ready !== 1'b0 || bus.d_rvalid !== 1'b0) begin
        errors++; $display("FAIL st_cycle%0d: ready=%b rvalid=%b want 0/0", c, bus.d_ready, bus.d_rvalid);
      end
      tick;
    end
    checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL st_rvalid_c3: got %b want 1", bus.d_rvalid); end
    checks++; if (bus.d_rdata !== 32'h12345678) begin errors++; $display("FAIL st_echo: got %h want 12345678", bus.d_rdata); end
    checks++; if (bus.d_err !== 1'b0) begin errors++; $display("FAIL st_err: got %b want 0", bus.d_err); end
    tick;
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL st_rvalid_c4: got %b want 0", bus.d_rvalid); end
    checks++; if (bus.d_rdata !== 32'h12345678) begin errors++; $display("FAIL st_hold: got %h want 12345678", bus.d_rdata); end
    xfer(1'b0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL ld40_data: got %h want 12345678", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL ld40_lat: got %0d want 3", lat); end
  endtask

  task automatic test_back_to_back;
    int lat;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_wdata = 32'hA;
    tick;
    bus.d_req = 1'b0;
    tick; tick;
    checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_st_rvalid: got %b want 1", bus.d_rvalid); end
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8; bus.d_wdata = 32'h0;
    tick;
    bus.d_req = 1'b0;
    checks++; if (bus.d_rvalid !== 1'b0 || bus.d_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_after_resp: rvalid=%b ready=%b want 0/0", bus.d_rvalid, bus.d_ready);
    end
    lat = 1;
    while (!bus.d_rvalid && lat < 20) begin tick; lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_lat: got %0d want 3", lat); end
    checks++; if (bus.d_rdata !== 32'hA) begin errors++; $display("FAIL b2b_data: got %h want 0000000a", bus.d_rdata); end
    tick;
  endtask

  task automatic test_collision;
    ld_write(10'd12, 32'h11111111);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h30; bus.d_wdata = 32'h77;
    tick;
    bus.d_req = 1'b0;
    tick; tick;
    checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL col_rvalid: got %b want 1", bus.d_rvalid); end
    bus.i_req = 1'b1; bus.i_addr = 32'h30;
    bus.ld_we = 1'b1; bus.ld_addr = 10'd12; bus.ld_data = 32'h99;
    tick;
    bus.ld_we = 1'b0;
    checks++; if (bus.i_data !== 32'h77) begin errors++; $display("FAIL col_fwd: got %h want 00000077", bus.i_data); end
    tick;
    bus.i_req = 1'b0;
    checks++; if (bus.i_data !== 32'h77) begin errors++; $display("FAIL col_store_wins: got %h want 00000077", bus.i_data); end
    tick;
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b0, 32'h41, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_ld_err: got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_ld_data: got %h want 0", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL mis_ld_lat: got %0d want 3", lat); end
    xfer(1'b1, 32'h42, 32'hBAD, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_st: err=%b data=%h want 1/0", er, rd); end
    xfer(1'b0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h12345678 || er !== 1'b0) begin
      errors++; $display("FAIL mis_st_nowrite: data=%h err=%b want 12345678/0", rd, er);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 32'h1000, 32'h55, rd, er, lat);
    xfer(1'b0, 32'h0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h55) begin errors++; $display("FAIL wrap: got %h want 00000055", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat;
    logic seen;
    ld_write(10'd8, 32'hCAFE0020);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h5;
    tick;
    bus.d_req = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h14;
    tick;
    rst = 1'b1;
    bus.i_req = 1'b0;
    #1;
    checks++; if (bus.i_valid !== 1'b0) begin errors++; $display("FAIL rmid_i_valid: got %b want 0", bus.i_valid); end
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", bus.d_ready); end
    seen = 1'b0;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.d_rvalid) seen = 1'b1;
      tick;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_rvalid: got %b want 0", seen); end
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b want 1", bus.d_ready); end
    xfer(1'b0, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFE0020) begin errors++; $display("FAIL rmid_nowrite: got %h want cafe0020", rd); end
  endtask

  initial begin
    test_reset;
    test_ifetch;
    test_store_load;
    test_back_to_back;
    test_collision;
    test_misaligned;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
